divider_array_sched: RTL and testbench

Sequencer and two-port arbiter for one shared combinational 16/8 array divider row, exact or approximate. It accepts divide requests from two requesters over valid/ready and grants them round-robin. It holds the divider operands stable for a fixed settle window, which treats the array as a multicycle path, then captures quotient and remainder into a registered response port. It sits between the requesting datapaths and a single divider instance, so area-heavy approximate dividers are not duplicated.

---
 rtl/divider_array_sched.sv | 147 ++++++++++++++
 tb/tb_divider_array_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_array_sched.sv
`default_nettype none
// ============================================================================
//  Module      : divider_array_sched
//  Description : Round-robin sequencer for one shared combinational 16/8
//                divider row. Operands are held for SETTLE_CYCLES (1..15),
//                then the quotient and remainder are captured into a
//                registered valid/ready response port.
//                Optional macro DIV_ERR_BYPASS_EN: error requests skip the
//                settle window and answer with q=r=8'hFF.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_array_sched #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_n,
    input  logic [7:0]  req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_n,
    input  logic [7:0]  req1_d,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_q,
    output logic [7:0]  rsp_r,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_cnt_init  = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_err;
    logic [15:0] r_div_n;
    logic [7:0]  r_div_d;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [7:0]  r_rsp_q;
    logic [7:0]  r_rsp_r;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic [15:0] w_n;
    logic [7:0]  w_d;
    logic        w_err;

    // Ties go to the requester that was not served last.
    assign w_idle     = (r_state == c_st_idle);
    assign w_grant    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept   = w_idle & (req0_valid | req1_valid);
    assign w_n        = w_grant ? req1_n : req0_n;
    assign w_d        = w_grant ? req1_d : req0_d;
    assign w_err      = (w_d == 8'd0) | (w_n[15:8] >= w_d);

    assign req0_ready = w_idle & req0_valid & ~w_grant;
    assign req1_ready = w_idle & req1_valid &  w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
            r_div_n      <= 16'd0;
            r_div_d      <= 8'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_q      <= 8'd0;
            r_rsp_r      <= 8'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_div_n      <= w_n;
                        r_div_d      <= w_d;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                        r_err        <= w_err;
                        r_cnt        <= c_cnt_init;
`ifdef DIV_ERR_BYPASS_EN
                        if (w_err) begin
                            r_rsp_q     <= 8'hFF;
                            r_rsp_r     <= 8'hFF;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= c_st_resp;
                        end else begin
                            r_state     <= c_st_settle;
                        end
`else
                        r_state      <= c_st_settle;
`endif
                    end
                end
                c_st_settle: begin
                    // The divider array is a multicycle path; sample only once it has settled.
                    if (r_cnt == 4'd0) begin
                        r_rsp_q     <= div_q;
                        r_rsp_r     <= div_r;
                        r_rsp_err   <= r_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_st_resp;
                    end else begin
                        r_cnt       <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign div_n     = r_div_n;
    assign div_d     = r_div_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_r     = r_rsp_r;
    assign rsp_err   = r_rsp_err;
    assign busy      = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_divider_array_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_array_sched
//  Description : Bench for divider_array_sched with SETTLE_CYCLES = 2, 1, 15
//                sharing one stimulus stream; honours DIV_ERR_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_array_sched;

    localparam int c_num = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [15:0] req0_n, req1_n;
    logic [7:0]  req0_d, req1_d;

    logic        rdy0 [c_num];
    logic        rdy1 [c_num];
    logic        rsp_valid [c_num];
    logic        rsp_id [c_num];
    logic        rsp_err [c_num];
    logic        busy [c_num];
    logic [15:0] div_n [c_num];
    logic [7:0]  div_d [c_num];
    logic [7:0]  div_q [c_num];
    logic [7:0]  div_r [c_num];
    logic [7:0]  rsp_q [c_num];
    logic [7:0]  rsp_r [c_num];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    // Exact divider; divide-by-zero returns all-ones quotient and n[7:0].
    function automatic logic [7:0] ref_q(input logic [15:0] n, input logic [7:0] d);
        logic [15:0] q;
        if (d == 8'd0) return 8'hFF;
        q = n / {8'd0, d};
        return q[7:0];
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] n, input logic [7:0] d);
        logic [15:0] r;
        if (d == 8'd0) return n[7:0];
        r = n % {8'd0, d};
        return r[7:0];
    endfunction

    for (genvar k = 0; k < c_num; k++) begin : g_dut
        assign div_q[k] = ref_q(div_n[k], div_d[k]);
        assign div_r[k] = ref_r(div_n[k], div_d[k]);

        divider_array_sched #(.SETTLE_CYCLES((k == 0) ? 2 : (k == 1) ? 1 : 15)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_ready (rdy0[k]),
            .req0_n     (req0_n),
            .req0_d     (req0_d),
            .req1_valid (req1_valid),
            .req1_ready (rdy1[k]),
            .req1_n     (req1_n),
            .req1_d     (req1_d),
            .div_n      (div_n[k]),
            .div_d      (div_d[k]),
            .div_q      (div_q[k]),
            .div_r      (div_r[k]),
            .rsp_valid  (rsp_valid[k]),
            .rsp_ready  (rsp_ready),
            .rsp_id     (rsp_id[k]),
            .rsp_q      (rsp_q[k]),
            .rsp_r      (rsp_r[k]),
            .rsp_err    (rsp_err[k]),
            .busy       (busy[k])
        );
    end

    // Transaction-level model: one in-flight request per instance.
    bit          m_ok = 1'b0;
    bit          m_settling [c_num];
    bit          m_resp [c_num];
    bit          m_last [c_num];
    bit          m_id [c_num];
    bit          m_perr [c_num];
    bit          m_rerr [c_num];
    int          m_age [c_num];
    logic [15:0] m_n [c_num];
    logic [7:0]  m_d [c_num];
    logic [7:0]  m_q [c_num];
    logic [7:0]  m_r [c_num];

    function automatic bit exp_idle(input int k);
        return !m_settling[k] && !m_resp[k];
    endfunction

    function automatic bit exp_grant(input int k);
        return (req0_valid && req1_valid) ? !m_last[k] : req1_valid;
    endfunction

    function automatic logic [15:0] sel_n(input int k);
        return exp_grant(k) ? req1_n : req0_n;
    endfunction

    function automatic logic [7:0] sel_d(input int k);
        return exp_grant(k) ? req1_d : req0_d;
    endfunction

    function automatic bit sel_err(input int k);
        logic [15:0] n;
        logic [7:0]  d;
        n = sel_n(k);
        d = sel_d(k);
        return (d == 8'd0) || (n[15:8] >= d);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ok <= 1'b1;
            for (int k = 0; k < c_num; k++) begin
                m_settling[k] <= 1'b0;
                m_resp[k]     <= 1'b0;
                m_last[k]     <= 1'b1;
                m_id[k]       <= 1'b0;
                m_perr[k]     <= 1'b0;
                m_rerr[k]     <= 1'b0;
                m_age[k]      <= 0;
                m_n[k]        <= 16'd0;
                m_d[k]        <= 8'd0;
                m_q[k]        <= 8'd0;
                m_r[k]        <= 8'd0;
            end
        end else begin
            for (int k = 0; k < c_num; k++) begin
                if (exp_idle(k)) begin
                    if (req0_valid || req1_valid) begin
                        m_n[k]    <= sel_n(k);
                        m_d[k]    <= sel_d(k);
                        m_id[k]   <= exp_grant(k);
                        m_last[k] <= exp_grant(k);
                        m_perr[k] <= sel_err(k);
`ifdef DIV_ERR_BYPASS_EN
                        if (sel_err(k)) begin
                            m_resp[k] <= 1'b1;
                            m_q[k]    <= 8'hFF;
                            m_r[k]    <= 8'hFF;
                            m_rerr[k] <= 1'b1;
                        end else begin
                            m_settling[k] <= 1'b1;
                            m_age[k]      <= 0;
                        end
`else
                        m_settling[k] <= 1'b1;
                        m_age[k]      <= 0;
`endif
                    end
                end else if (m_settling[k]) begin
                    if (m_age[k] == settle_of(k) - 1) begin
                        m_settling[k] <= 1'b0;
                        m_resp[k]     <= 1'b1;
                        m_q[k]        <= ref_q(m_n[k], m_d[k]);
                        m_r[k]        <= ref_r(m_n[k], m_d[k]);
                        m_rerr[k]     <= m_perr[k];
                    end else begin
                        m_age[k] <= m_age[k] + 1;
                    end
                end else if (m_resp[k] && rsp_ready) begin
                    m_resp[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < c_num; k++) begin
                chk("req0_ready", k, rdy0[k], exp_idle(k) && req0_valid && !exp_grant(k));
                chk("req1_ready", k, rdy1[k], exp_idle(k) && req1_valid && exp_grant(k));
                chk("rsp_valid",  k, rsp_valid[k], m_resp[k]);
                chk("busy",       k, busy[k], !exp_idle(k));
                chk("div_n",      k, div_n[k], m_n[k]);
                chk("div_d",      k, div_d[k], m_d[k]);
                chk("rsp_id",     k, rsp_id[k], m_id[k]);
                chk("rsp_q",      k, rsp_q[k], m_q[k]);
                chk("rsp_r",      k, rsp_r[k], m_r[k]);
                chk("rsp_err",    k, rsp_err[k], m_rerr[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst        = 1'b0;
    endtask

    task automatic err_case(input logic [15:0] n, input logic [7:0] d,
                            input logic [7:0] q_raw, input logic [7:0] r_raw);
        int lat;
        logic [7:0] q, r;
        logic e;
        int exp_lat;
        logic [7:0] exp_q, exp_r;
        lat = 0; q = 8'd0; r = 8'd0; e = 1'b0;
`ifdef DIV_ERR_BYPASS_EN
        exp_lat = 1; exp_q = 8'hFF; exp_r = 8'hFF;
`else
        exp_lat = 3; exp_q = q_raw; exp_r = r_raw;
`endif
        do_reset();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_n = n; req0_d = d;
        tick();
        req0_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (rsp_valid[0] && lat == 0) begin
                lat = c; q = rsp_q[0]; r = rsp_r[0]; e = rsp_err[0];
            end
            tick();
        end
        chk("err_latency", 0, lat, exp_lat);
        chk("err_q", 0, q, exp_q);
        chk("err_r", 0, r, exp_r);
        chk("err_flag", 0, e, 1'b1);
    endtask

    initial begin
        int g_cnt, s_cnt, w;
        int g_id [4];
        int g_cyc [4];
        int s_id [4];
        int s_q [4];
        int s_r [4];
        int first [c_num];
        logic [7:0] q15;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_n = 16'd0; req0_d = 8'd0; req1_n = 16'd0; req1_d = 8'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 0, rsp_valid[0], 1'b0);
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_div_n", 0, div_n[0], 16'd0);
        chk("rst_rsp_q", 0, rsp_q[0], 8'd0);
        tick();

        // Single request: 100 / 7
        req0_valid = 1'b1; req0_n = 16'd100; req0_d = 8'd7;
        @(negedge clk);
        chk("single_ready0", 0, rdy0[0], 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk); chk("single_v_t1", 0, rsp_valid[0], 1'b0);
        tick();
        @(negedge clk); chk("single_v_t2", 0, rsp_valid[0], 1'b0);
        tick();
        @(negedge clk);
        chk("single_v_t3", 0, rsp_valid[0], 1'b1);
        chk("single_q", 0, rsp_q[0], 8'd14);
        chk("single_r", 0, rsp_r[0], 8'd2);
        chk("single_id", 0, rsp_id[0], 1'b0);
        chk("single_err", 0, rsp_err[0], 1'b0);
        tick();

        // Tie and alternation
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_n = 16'd50; req0_d = 8'd5;
        req1_valid = 1'b1; req1_n = 16'd81; req1_d = 8'd9;
        g_cnt = 0; s_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            g_id[i] = -1; g_cyc[i] = -1; s_id[i] = -1; s_q[i] = -1; s_r[i] = -1;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((rdy0[0] || rdy1[0]) && g_cnt < 4) begin
                g_id[g_cnt] = rdy1[0] ? 1 : 0; g_cyc[g_cnt] = i; g_cnt++;
            end
            if (rsp_valid[0] && s_cnt < 4) begin
                s_id[s_cnt] = int'(rsp_id[0]); s_q[s_cnt] = int'(rsp_q[0]); s_r[s_cnt] = int'(rsp_r[0]); s_cnt++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_grant_cnt", 0, g_cnt, 3);
        chk("tie_grant0", 0, g_id[0], 0);
        chk("tie_grant1", 0, g_id[1], 1);
        chk("tie_grant2", 0, g_id[2], 0);
        chk("tie_spacing", 0, g_cyc[1] - g_cyc[0], 4);
        chk("tie_rsp0_q", 0, s_q[0], 10);
        chk("tie_rsp0_r", 0, s_r[0], 0);
        chk("tie_rsp0_id", 0, s_id[0], 0);
        chk("tie_rsp1_q", 0, s_q[1], 9);
        chk("tie_rsp1_r", 0, s_r[1], 0);
        chk("tie_rsp1_id", 0, s_id[1], 1);

        // Backpressure
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_n = 16'd200; req0_d = 8'd3;
        req1_valid = 1'b1; req1_n = 16'd90;  req1_d = 8'd9;
        @(negedge clk);
        w = 0;
        while (!rsp_valid[0] && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("bp_wait", 0, rsp_valid[0], 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_q", 0, rsp_q[0], 8'd66);
            chk("bp_r", 0, rsp_r[0], 8'd2);
            chk("bp_id", 0, rsp_id[0], 1'b0);
            chk("bp_rdy0", 0, rdy0[0], 1'b0);
            chk("bp_rdy1", 0, rdy1[0], 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 0, rsp_valid[0], 1'b1);
        chk("bp_hs_rdy1", 0, rdy1[0], 1'b0);
        tick();
        @(negedge clk);
        chk("bp_next_rdy1", 0, rdy1[0], 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Errors: overflow and divide-by-zero
        err_case(16'h0A00, 8'h05, 8'h00, 8'h00);
        err_case(16'h1234, 8'h00, 8'hFF, 8'h34);

        // Reset in the second settle cycle
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_n = 16'd100; req0_d = 8'd7;
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, busy[0], 1'b0);
        chk("abort_rsp_valid", 0, rsp_valid[0], 1'b0);
        chk("abort_div_n", 0, div_n[0], 16'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("abort_no_rsp", 0, rsp_valid[0], 1'b0);
        end
        tick();

        // Settle window across the three instances
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_n = 16'd1000; req0_d = 8'd9;
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < c_num; k++) first[k] = -1;
        q15 = 8'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < c_num; k++) begin
                if (rsp_valid[k] && first[k] < 0) begin
                    first[k] = c;
                    if (k == 2) q15 = rsp_q[k];
                end
            end
            tick();
        end
        chk("settle2_lat", 0, first[0], 3);
        chk("settle1_lat", 1, first[1], 2);
        chk("settle15_lat", 2, first[2], 16);
        chk("settle15_q", 2, q15, 8'd111);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_n = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2047)) : 16'($urandom);
            req1_n = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2047)) : 16'($urandom);
            req0_d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            req1_d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
            rsp_ready = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
